// File: rtl/sram_1rw_port_ctrl.sv
// Single-port SRAM controller: registered strobes, two-cycle writes, held read response.
// Define SRAM_CTRL_STATS_EN to add saturating rd_count/wr_count command counters.
module sram_1rw_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic                  sram_oeb,
    inout  wire  [DATA_WIDTH-1:0] sram_data
`ifdef SRAM_CTRL_STATS_EN
    ,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
`endif
);

    // state   | meaning
    // IDLE    | ready for a command, SRAM deselected
    // ACCESS  | strobes asserted; write data on the bus for writes
    // CAPTURE | read strobes held, bus sampled at the end of this cycle
    // RESP    | read data held until the consumer takes it
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    sram_csb_q, sram_csb_d;
    logic                    sram_web_q, sram_web_d;
    logic                    sram_oeb_q, sram_oeb_d;
    logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    cmd_accept;
    logic                    bus_drive;

    assign cmd_accept = (state_q == ST_IDLE) && cmd_valid;

    always_comb begin
        state_d     = state_q;
        sram_csb_d  = sram_csb_q;
        sram_web_d  = sram_web_q;
        sram_oeb_d  = sram_oeb_q;
        sram_addr_d = sram_addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d     = ST_ACCESS;
                    sram_csb_d  = 1'b0;
                    sram_web_d  = ~cmd_we;
                    sram_oeb_d  = cmd_we;
                    sram_addr_d = cmd_addr;
                    wdata_d     = cmd_wdata;
                end
            end
            ST_ACCESS: begin
                if (!sram_web_q) begin
                    state_d    = ST_IDLE;
                    sram_csb_d = 1'b1;
                    sram_web_d = 1'b1;
                    sram_oeb_d = 1'b1;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                rdata_d     = sram_data;
                rsp_valid_d = 1'b1;
                sram_csb_d  = 1'b1;
                sram_oeb_d  = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                // rsp_valid is already set here, so a ready seen while capturing cannot complete
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sram_csb_q  <= 1'b1;
            sram_web_q  <= 1'b1;
            sram_oeb_q  <= 1'b1;
            sram_addr_q <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sram_csb_q  <= sram_csb_d;
            sram_web_q  <= sram_web_d;
            sram_oeb_q  <= sram_oeb_d;
            sram_addr_q <= sram_addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Only a write in ACCESS drives the bus; oeb is high then, so no contention.
    assign bus_drive = (state_q == ST_ACCESS) && !sram_web_q;
    assign sram_data = bus_drive ? wdata_q : {DATA_WIDTH{1'bz}};

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign sram_addr = sram_addr_q;
    assign sram_csb  = sram_csb_q;
    assign sram_web  = sram_web_q;
    assign sram_oeb  = sram_oeb_q;

`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (cmd_accept && !cmd_we && (rd_count_q != 16'hFFFF)) begin
            rd_count_d = rd_count_q + 16'd1;
        end
        if (cmd_accept && cmd_we && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: doc/sram_1rw_port_ctrl.md
SRAM_1RW_PORT_CTRL -- requirements
Module: sram_1rw_port_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data word width.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the word-address width (depth 1<<ADDR_WIDTH).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 cmd_valid  input  1  SHALL indicate that a command is offered.
REQ-006 cmd_ready  output  1  SHALL indicate that a command can be accepted.
REQ-007 cmd_we  input  1  SHALL select write (1) or read (0).
REQ-008 cmd_addr  input  ADDR_WIDTH  SHALL carry the command word address.
REQ-009 cmd_wdata  input  DATA_WIDTH  SHALL carry the write data.
REQ-010 rsp_valid  output  1  SHALL indicate that read data is held.
REQ-011 rsp_ready  input  1  SHALL indicate that the consumer takes the read data.
REQ-012 rsp_rdata  output  DATA_WIDTH  SHALL carry the read data.
REQ-013 sram_addr  output  ADDR_WIDTH  SHALL be the registered SRAM address.
REQ-014 sram_csb, sram_web, sram_oeb  output  1 each  SHALL be the registered, active-low chip select, write enable and output enable.
REQ-015 sram_data  inout  DATA_WIDTH  SHALL be the shared SRAM data bus.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, CAPTURE and RESP.
REQ-017 cmd_ready SHALL be 1 only in IDLE.
REQ-018 A handshake (cmd_valid and cmd_ready at an edge) SHALL move the FSM to ACCESS and register the command onto the SRAM outputs:
  - sram_csb=0
  - sram_web=~cmd_we
  - sram_oeb=cmd_we
  - sram_addr=cmd_addr
  - cmd_wdata into the write-data register.
REQ-019 Write path:
  - sram_data SHALL be driven with the write-data register only while in ACCESS with sram_web=0; otherwise it SHALL be high-Z.
  - ACCESS SHALL go to IDLE with csb, web and oeb all 1.
  - A write SHALL occupy 2 cycles, accept edge to the next accept edge.
REQ-020 Read path: ACCESS SHALL go to CAPTURE with csb=0, web=1 and oeb=0 held, and with the address unchanged.
REQ-021 At the CAPTURE edge, the block SHALL:
  - latch sram_data into rsp_rdata
  - set rsp_valid=1
  - set csb=1, oeb=1
  - go to RESP.
  This gives rsp_valid exactly 2 edges after the accept edge.
REQ-022 RESP SHALL hold rsp_valid and rsp_rdata stable until rsp_ready=1 at an edge, then clear rsp_valid and go to IDLE.
REQ-023 rsp_ready=1 at the same edge that rsp_valid rises SHALL NOT complete the handshake; completion requires rsp_valid already set.
REQ-024 cmd_valid asserted outside IDLE SHALL be ignored, with no state or output change.
REQ-025 The controller SHALL never drive sram_data while sram_oeb=0 (no bus contention).
REQ-026 A read of an address written by the immediately preceding command SHALL return the new data.

Reset
REQ-027 While rst=1 at an edge, the block SHALL set:
  - state IDLE
  - sram_csb=1, sram_web=1, sram_oeb=1
  - sram_addr=0
  - rsp_valid=0, rsp_rdata=0
  - sram_data high-Z
  - counters 0.
REQ-028 rst asserted in any state, including mid-read, SHALL abort the operation and discard any captured data.
REQ-029 The block SHALL not produce a response for an aborted command.
REQ-030 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-031 With SRAM_CTRL_STATS_EN defined, the block SHALL add outputs rd_count and wr_count (16 bits each).
REQ-032 Each counter SHALL increment on an accepted read or write command respectively, and SHALL saturate at 16'hFFFF.
REQ-033 Without SRAM_CTRL_STATS_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Reset: assert rst during a read in CAPTURE -> next cycle csb=1, oeb=1, rsp_valid=0, cmd_ready=1.
REQ-035 Write then read:
  - write addr 8'h05 data 32'hDEADBEEF, then read addr 8'h05
  - required: rsp_valid 2 edges after the read accept, with rsp_rdata=32'hDEADBEEF.
REQ-036 Backpressure:
  - read with rsp_ready held 0 for 5 cycles
  - required: rsp_rdata stable, cmd_ready=0 throughout, cmd_valid pulses ignored
  - then rsp_ready=1 -> IDLE on the next edge.
REQ-037 Back-to-back writes:
  - 4 writes to addresses 8'hFC..8'hFF with cmd_valid held high
  - required: accepts every 2 cycles, and sram_data is never driven while oeb=0.
REQ-038 With SRAM_CTRL_STATS_EN: 3 writes and 2 reads -> wr_count=3, rd_count=2; preset to 16'hFFFF plus one write -> wr_count stays 16'hFFFF.
